uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning TX FIFO depth in bytes (power of two, 2..256).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port wr_en  input  1  one-cycle byte-write strobe from the MMIO TX-data register.
REQ-005 The block SHALL have port wr_data  input  8  byte to transmit.
REQ-006 The block SHALL have port baud_div  input  16  bit period minus one, in clk cycles.
REQ-007 The block SHALL have port tx  output  1  serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  frame in progress.
REQ-009 The block SHALL have port fifo_full  output  1  FIFO holds DEPTH bytes.
REQ-010 The block SHALL have port fifo_empty  output  1  FIFO holds 0 bytes.
REQ-011 The block SHALL have port fifo_count  output  $clog2(DEPTH)+1  bytes queued, excluding the byte being shifted.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-013 A write SHALL be accepted when wr_en=1 and fifo_full=0, judged at the start of the cycle; the FIFO SHALL then store wr_data at the tail.
REQ-014 A write with fifo_full=1 SHALL be discarded; overflow SHALL set and hold until reset. FIFO contents SHALL NOT change.
REQ-015 An accepted write and a pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-016 Pointers SHALL wrap modulo DEPTH. fifo_count SHALL reach DEPTH exactly when full.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, and STOP. busy SHALL be 1 in every state except IDLE.
REQ-018 IDLE: tx=1. If fifo_empty=0, on the next edge the FSM SHALL pop the head byte into the shift register, latch baud_div, clear the bit counter and the baud counter, and enter START.
REQ-019 Each bit period SHALL last latched_div+1 cycles. The baud counter SHALL count 0..latched_div, and the period SHALL end on the cycle the count equals latched_div.
REQ-020 START: tx=0 for one bit period, then go to DATA.
REQ-021 DATA: send 8 bits, LSB first, one bit per period. After bit 7 go to PARITY if the parity feature is compiled in, otherwise to STOP.
REQ-022 STOP: tx=1 for one bit period. At its end, if fifo_empty=0, pop and enter START on the same edge (back-to-back frames, no idle gap). Otherwise enter IDLE.
REQ-023 tx SHALL be driven from a register, with no combinational glitches.
REQ-024 Latency: a write accepted at edge E into an empty FIFO with FSM in IDLE SHALL give tx=0 from edge E+1.
REQ-025 Changes to baud_div mid-frame SHALL NOT affect the current frame. The new value SHALL apply at the next START.
REQ-026 baud_div=0 SHALL give one clk per bit.

Reset
REQ-027 On rst=1 at a clock edge: tx=1, busy=0, FSM=IDLE, FIFO flushed (fifo_empty=1, fifo_full=0, fifo_count=0), overflow=0, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame: tx=1 from the edge that samples rst, and the aborted byte is lost.
REQ-029 A wr_en asserted during rst=1 SHALL be ignored.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL be present and SHALL send one even-parity bit (XOR of the 8 data bits) between DATA and STOP. A frame SHALL then be 11 bit periods.
REQ-031 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent. A frame SHALL be 10 bit periods.

Verification
REQ-032 Bench SHALL cover: baud_div=3, write 0xA5 -> tx=0 from the next edge; sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (plus parity 0 when UART_TX_PARITY_EN is defined); busy drops after 40 (44) cycles.
REQ-033 Bench SHALL cover: baud_div=0, write 0x01,0x02,0x03 on consecutive cycles -> three back-to-back frames with no idle cycle between a STOP bit and the next START bit; fifo_count peaks at 2.
REQ-034 Bench SHALL cover: DEPTH=16, baud_div=100, 18 consecutive writes -> 1 popped, 16 queued, fifo_full=1, 1 write dropped, overflow=1 and stays 1 after the FIFO drains.
REQ-035 Bench SHALL cover: write while fifo_count=DEPTH-1 on the same cycle STOP pops -> fifo_count unchanged, fifo_full=0, no overflow.
REQ-036 Bench SHALL cover: change baud_div from 3 to 7 during DATA -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-037 Bench SHALL cover: assert rst during DATA with 5 bytes queued -> tx=1, busy=0, fifo_count=0, overflow=0 one edge later; no further frames are sent.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a byte FIFO, 8 data bits, one stop bit, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic [15:0]            baud_div,
    output logic                   tx,
    output logic                   busy,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic            r_tx;
    logic [7:0]      r_shift;
    logic [15:0]     r_div;
    logic [15:0]     r_baud_cnt;
    logic [2:0]      r_bit_cnt;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_tx_nxt;
    logic            w_bit_end;
    logic [7:0]      w_head;

    assign fifo_full  = (r_count == FULL_CNT);
    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);

    assign w_push    = wr_en & ~fifo_full & ~rst;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_baud_cnt == r_div);

    // Next-state and next tx level; tx is registered so the line never glitches
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    if (!fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en && fifo_full) r_overflow <= 1'b1;
            r_tx <= w_tx_nxt;
            // Counter idles at zero so a new frame always starts a full bit period
            if (w_pop || w_bit_end) begin
                r_baud_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_pop) begin
                r_bit_cnt <= '0;
            end else if (r_state == DATA && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Datapath registers carry no reset; they are reloaded on every pop
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
        if (w_pop) begin
            r_shift <= w_head;
            r_div   <= baud_div;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
        end else if (r_state == DATA && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (DEPTH=16); honours UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] baud_div;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;
    int max_cnt  = 0;

    uart_tx_ctrl #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .baud_div   (baud_div),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, required end before 1ms");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Line level of frame position k: start, 8 data LSB first, [parity], stop
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check_bits(input string tag, input logic [7:0] d, input int per,
                              input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            for (int c = 0; c < per; c++) begin
                tick();
                wr_en = 1'b0;
                check($sformatf("%s_tx_b%0d_c%0d", tag, k, c), tx, exp_bit(d, k));
                if (c == 0) check($sformatf("%s_busy_b%0d", tag, k), busy, 1);
            end
        end
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        int a5_seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        int a5_seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        bit done;

        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'h55;
        baud_div = 16'd3;

        // Reset state, with a write held during reset
        tick();
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        tick();
        check("rst_wr_ignored_empty", fifo_empty, 1);
        check("rst_wr_ignored_busy", busy, 0);
        check("rst_wr_ignored_tx", tx, 1);

        // Single frame 0xA5 at 4 clocks per bit
        baud_div = 16'd3;
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("a5_queued", fifo_count, 1);
        check("a5_idle_tx", tx, 1);
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("a5_tx_b%0d_c%0d", k, c), tx, a5_seq[k]);
                check($sformatf("a5_busy_b%0d_c%0d", k, c), busy, 1);
            end
        end
        tick();
        check("a5_busy_end", busy, 0);
        check("a5_tx_end", tx, 1);
        check("a5_count_end", fifo_count, 0);

        // Back-to-back frames at one clock per bit
        do_reset();
        baud_div = 16'd0;
        max_cnt  = 0;
        wr_en    = 1'b1;
        wr_data  = 8'h01;
        tick();
        check("b2b_cnt_e1", fifo_count, 1);
        wr_data = 8'h02;
        tick();
        check("b2b_start_e2", tx, 0);
        check("b2b_cnt_e2", fifo_count, 1);
        wr_data = 8'h03;
        tick();
        wr_en = 1'b0;
        check("b2b_bit0_e3", tx, 1);
        check("b2b_cnt_e3", fifo_count, 2);
        check_bits("b2b_f1", 8'h01, 1, 2, NB-1);
        check_bits("b2b_f2", 8'h02, 1, 0, NB-1);
        check_bits("b2b_f3", 8'h03, 1, 0, NB-1);
        tick();
        check("b2b_busy_end", busy, 0);
        check("b2b_peak", max_cnt, 2);

        // Overflow: 18 writes into a 16-deep FIFO
        do_reset();
        baud_div = 16'd100;
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h40 + i);
            tick();
            if (i == 16) begin
                check("ovf_full_at16", fifo_full, 1);
                check("ovf_flag_at16", overflow, 0);
            end
            if (i == 17) begin
                check("ovf_count", fifo_count, 16);
                check("ovf_full", fifo_full, 1);
                check("ovf_flag", overflow, 1);
                check("ovf_busy", busy, 1);
            end
        end
        wr_en    = 1'b0;
        baud_div = 16'd0;
        done     = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            tick();
            if (fifo_empty && !busy) done = 1'b1;
        end
        check("ovf_drain_done", done, 1);
        check("ovf_sticky", overflow, 1);
        check("ovf_drained_count", fifo_count, 0);
        check("ovf_drained_full", fifo_full, 0);

        // Write on the same edge that STOP pops with DEPTH-1 queued
        do_reset();
        check("sim_rst_ovf", overflow, 0);
        baud_div = 16'd1;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            tick();
        end
        wr_en = 1'b0;
        check("sim_count15", fifo_count, 15);
        for (int c = 0; c < 2*NB - 15; c++) tick();
        check("sim_pre_count", fifo_count, 15);
        check("sim_pre_stop", tx, 1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("sim_count", fifo_count, 15);
        check("sim_full", fifo_full, 0);
        check("sim_ovf", overflow, 0);
        check("sim_next_start", tx, 0);

        // baud_div change mid-frame applies to the next frame only
        do_reset();
        baud_div = 16'd3;
        wr_en    = 1'b1;
        wr_data  = 8'h3C;
        tick();
        wr_en = 1'b0;
        check_bits("bd_f1a", 8'h3C, 4, 0, 1);
        baud_div = 16'd7;
        wr_en    = 1'b1;
        wr_data  = 8'hC3;
        check_bits("bd_f1b", 8'h3C, 4, 2, NB-1);
        check_bits("bd_f2", 8'hC3, 8, 0, NB-1);
        tick();
        check("bd_busy_end", busy, 0);

        // Reset during DATA with 5 bytes queued
        do_reset();
        baud_div = 16'd3;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 + i);
            tick();
        end
        wr_en = 1'b0;
        check("mrst_count5", fifo_count, 5);
        check("mrst_data_bit0", tx, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_tx", tx, 1);
        check("mrst_busy", busy, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_empty", fifo_empty, 1);
        check("mrst_ovf", overflow, 0);
        for (int c = 0; c < 60; c++) begin
            tick();
            check($sformatf("mrst_quiet_tx_c%0d", c), tx, 1);
        end
        check("mrst_quiet_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
